// File: rtl/riscv_pkg.sv
// Shared RV32I decode types, opcode/funct constants and the ID/EX pipeline record.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] funct3_t;
    typedef logic [6:0] funct7_t;

    localparam opcode_t OPCODE_LOAD   = 7'b0000011;
    localparam opcode_t OPCODE_STORE  = 7'b0100011;
    localparam opcode_t OPCODE_BRANCH = 7'b1100011;
    localparam opcode_t OPCODE_JAL    = 7'b1101111;
    localparam opcode_t OPCODE_JALR   = 7'b1100111;
    localparam opcode_t OPCODE_LUI    = 7'b0110111;
    localparam opcode_t OPCODE_AUIPC  = 7'b0010111;
    localparam opcode_t OPCODE_OP     = 7'b0110011;
    localparam opcode_t OPCODE_OP_IMM = 7'b0010011;

    localparam funct7_t F7_SUB = 7'b0100000;
    localparam funct7_t F7_SRA = 7'b0100000;

    localparam funct3_t F3_ADD_SUB = 3'b000;
    localparam funct3_t F3_SLL     = 3'b001;
    localparam funct3_t F3_SR      = 3'b101;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic            valid;
        opcode_t         opcode;
        funct3_t         funct3;
        funct7_t         funct7;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate, zero-extended shamt for shift-immediates.
// Latency: combinational.
// Backpressure: none.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    opcode_t opcode;
    funct3_t funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Select the immediate layout implied by the opcode; formats without one yield 0
    always_comb begin
        imm = '0;
        case (opcode)
            OPCODE_OP_IMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SR) begin
                    imm = {27'b0, instr[24:20]};
                end else begin
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPCODE_LOAD, OPCODE_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OPCODE_STORE:             imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPCODE_BRANCH:            imm = {{19{instr[31]}}, instr[31], instr[7],
                                             instr[30:25], instr[11:8], 1'b0};
            OPCODE_LUI, OPCODE_AUIPC: imm = {instr[31:12], 12'b0};
            OPCODE_JAL:               imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                             instr[20], instr[30:21], 1'b0};
            default:                  imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: field split, operand select, load-use bubble, illegal flagging into ID/EX.
// Latency: 1 cycle accept-to-ex_valid; full throughput when no hazard. Optional RV_DECODE_PERF_EN adds counters.
// Backpressure: ex_valid && !ex_ready freezes ID/EX and drops if_ready; flush overrides and drains.
module rv_decode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output opcode_t         ex_opcode,
    output funct3_t         ex_funct3,
    output funct7_t         ex_funct7,
    output logic [XLEN-1:0] ex_operand_a,
    output logic [XLEN-1:0] ex_operand_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_illegal
`ifdef RV_DECODE_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     instr_cnt
`endif
);

    id_ex_t          id_ex_q;
    id_ex_t          id_ex_d;
    logic [XLEN-1:0] imm;
    opcode_t         opcode;
    funct3_t         funct3;
    funct7_t         funct7_raw;
    logic [4:0]      rd;
    logic            is_illegal;
    logic            writes_rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            hazard;
    logic            advance;

    assign opcode     = if_instr[6:0];
    assign rd         = if_instr[11:7];
    assign funct3     = if_instr[14:12];
    assign funct7_raw = if_instr[31:25];
    assign rs1_addr   = if_instr[19:15];
    assign rs2_addr   = if_instr[24:20];

    imm_gen u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // Classify the incoming instruction: legality, source usage and write-back intent
    always_comb begin
        is_illegal = 1'b0;
        writes_rd  = 1'b0;
        rs1_used   = 1'b1;
        rs2_used   = 1'b0;
        case (opcode)
            OPCODE_OP: begin
                writes_rd  = 1'b1;
                rs2_used   = 1'b1;
                is_illegal = !((funct7_raw == 7'b0) ||
                               (funct7_raw == F7_SUB &&
                                (funct3 == F3_ADD_SUB || funct3 == F3_SR)));
            end
            OPCODE_OP_IMM: begin
                writes_rd = 1'b1;
                if (funct3 == F3_SLL) begin
                    is_illegal = (funct7_raw != 7'b0);
                end else if (funct3 == F3_SR) begin
                    is_illegal = !(funct7_raw == 7'b0 || funct7_raw == F7_SRA);
                end
            end
            OPCODE_LOAD, OPCODE_JALR: writes_rd = 1'b1;
            OPCODE_STORE, OPCODE_BRANCH: rs2_used = 1'b1;
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: begin
                writes_rd = 1'b1;
                rs1_used  = 1'b0;
            end
            default: is_illegal = 1'b1;
        endcase
    end

    // Build the ID/EX record for the instruction fetch is presenting
    always_comb begin
        id_ex_d        = '0;
        id_ex_d.valid  = 1'b1;
        id_ex_d.opcode = opcode;
        id_ex_d.funct3 = funct3;
        // OP-IMM only carries funct7 for shifts so a negative ADDI never looks like SUB
        if (opcode == OPCODE_OP || (opcode == OPCODE_OP_IMM && funct3 == F3_SR)) begin
            id_ex_d.funct7 = funct7_raw;
        end
        if (opcode == OPCODE_LUI) begin
            id_ex_d.operand_a = '0;
        end else if (opcode == OPCODE_AUIPC || opcode == OPCODE_JAL) begin
            id_ex_d.operand_a = if_pc;
        end else begin
            id_ex_d.operand_a = rs1_data;
        end
        if (opcode == OPCODE_OP || opcode == OPCODE_BRANCH) begin
            id_ex_d.operand_b = rs2_data;
        end else if (opcode == OPCODE_JAL || opcode == OPCODE_JALR) begin
            id_ex_d.operand_b = 32'd4;
        end else begin
            id_ex_d.operand_b = imm;
        end
        id_ex_d.store_data = rs2_data;
        id_ex_d.imm        = imm;
        id_ex_d.pc         = if_pc;
        id_ex_d.rd         = rd;
        id_ex_d.reg_write  = writes_rd && (rd != 5'd0) && !is_illegal;
        id_ex_d.mem_read   = (opcode == OPCODE_LOAD) && !is_illegal;
        id_ex_d.mem_write  = (opcode == OPCODE_STORE) && !is_illegal;
        id_ex_d.illegal    = is_illegal;
    end

    assign hazard = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) && if_valid &&
                    ((rs1_used && rs1_addr == id_ex_q.rd) ||
                     (rs2_used && rs2_addr == id_ex_q.rd));
    assign advance  = !id_ex_q.valid || ex_ready;
    assign if_ready = flush || (advance && !hazard);

    // ID/EX register: reset clears, flush kills, advance loads the instruction or a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_q <= '0;
        end else if (flush) begin
            id_ex_q.valid <= 1'b0;
        end else if (advance) begin
            if (if_valid && !hazard) begin
                id_ex_q <= id_ex_d;
            end else begin
                id_ex_q.valid <= 1'b0;
            end
        end
    end

    assign ex_valid      = id_ex_q.valid;
    assign ex_opcode     = id_ex_q.opcode;
    assign ex_funct3     = id_ex_q.funct3;
    assign ex_funct7     = id_ex_q.funct7;
    assign ex_operand_a  = id_ex_q.operand_a;
    assign ex_operand_b  = id_ex_q.operand_b;
    assign ex_store_data = id_ex_q.store_data;
    assign ex_imm        = id_ex_q.imm;
    assign ex_pc         = id_ex_q.pc;
    assign ex_rd         = id_ex_q.rd;
    assign ex_reg_write  = id_ex_q.reg_write;
    assign ex_mem_read   = id_ex_q.mem_read;
    assign ex_mem_write  = id_ex_q.mem_write;
    assign ex_illegal    = id_ex_q.illegal;

`ifdef RV_DECODE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] instr_cnt_q;

    // Saturating counts of surviving accepts and of cycles fetch was held off
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (if_valid && if_ready && !flush && instr_cnt_q != 32'hFFFF_FFFF) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if (if_valid && !if_ready && !flush && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed plan steps then randomized traffic vs a reference model.
// Latency: model expects ID/EX update one edge after the inputs are presented.
// Backpressure: ex_ready, flush and reset randomized; model tracks hold, bubble and kill.
module tb_rv_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_operand_a;
    logic [31:0] ex_operand_b;
    logic [31:0] ex_store_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;
`ifdef RV_DECODE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] m_icnt;
    logic [31:0] m_scnt;
    logic [31:0] snap;
`endif

    rv_decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_funct7     (ex_funct7),
        .ex_operand_a  (ex_operand_a),
        .ex_operand_b  (ex_operand_b),
        .ex_store_data (ex_store_data),
        .ex_imm        (ex_imm),
        .ex_pc         (ex_pc),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_illegal    (ex_illegal)
`ifdef RV_DECODE_PERF_EN
        ,
        .stall_cnt     (stall_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } ref_t;

    int   n_vec;
    int   n_bad;
    ref_t m;
    logic obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] s;
        s = 32'd1 << (bits - 1);
        return (v ^ s) - s;
    endfunction

    // Expected decode of one instruction, straight from the RV32I field rules
    function automatic ref_t decode_ref(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] d1, input logic [31:0] d2);
        ref_t       r;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        r = '0;
        r.valid  = 1'b1;
        r.opcode = op;
        r.f3     = f3;
        r.rd     = ins[11:7];
        r.pc     = pc;
        r.sd     = d2;
        case (op)
            7'h13:        r.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20])
                                                              : sext(32'(ins[31:20]), 12);
            7'h03, 7'h67: r.imm = sext(32'(ins[31:20]), 12);
            7'h23:        r.imm = sext(32'(ins[31:25]) * 32 + 32'(ins[11:7]), 12);
            7'h63:        r.imm = sext(32'(ins[31]) * 4096 + 32'(ins[7]) * 2048 +
                                       32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2, 13);
            7'h37, 7'h17: r.imm = 32'(ins[31:12]) * 4096;
            7'h6F:        r.imm = sext(32'(ins[31]) * 1048576 + 32'(ins[19:12]) * 4096 +
                                       32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2, 21);
            default:      r.imm = 32'd0;
        endcase
        r.ill = !(op inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13});
        if (op == 7'h33) r.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        if (op == 7'h13 && f3 == 3'd1) r.ill = (f7 != 7'h00);
        if (op == 7'h13 && f3 == 3'd5) r.ill = !(f7 == 7'h00 || f7 == 7'h20);
        r.f7 = (op == 7'h33 || (op == 7'h13 && f3 == 3'd5)) ? f7 : 7'h00;
        r.a  = (op == 7'h37) ? 32'd0 : (op == 7'h17 || op == 7'h6F) ? pc : d1;
        r.b  = (op == 7'h33 || op == 7'h63) ? d2 : (op == 7'h6F || op == 7'h67) ? 32'd4 : r.imm;
        r.rw = (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) &&
               (r.rd != 5'd0) && !r.ill;
        r.mr = (op == 7'h03) && !r.ill;
        r.mw = (op == 7'h23) && !r.ill;
        return r;
    endfunction

    // One clock: drive inputs, check handshake at negedge, check ID/EX after the edge
    task automatic apply(input logic r, input logic iv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                         input logic fl, input logic er);
        logic hz;
        logic adv;
        logic rdy;
        ref_t nx;
        rst_n = r; if_valid = iv; if_instr = ins; if_pc = pc;
        rs1_data = d1; rs2_data = d2; flush = fl; ex_ready = er;
        @(negedge clk);
        hz  = m.valid && m.mr && (m.rd != 5'd0) && iv &&
              ((!(ins[6:0] inside {7'h37, 7'h17, 7'h6F}) && ins[19:15] == m.rd) ||
               ((ins[6:0] inside {7'h33, 7'h23, 7'h63}) && ins[24:20] == m.rd));
        adv = !m.valid || er;
        rdy = fl || (adv && !hz);
        obs_rdy = if_ready;
        chk("if_ready", 32'(if_ready), 32'(rdy));
        chk("rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
        chk("rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
        if (!r) nx = '0;
        else if (fl) begin nx = m; nx.valid = 1'b0; end
        else if (adv && iv && !hz) nx = decode_ref(ins, pc, d1, d2);
        else if (adv) begin nx = m; nx.valid = 1'b0; end
        else nx = m;
`ifdef RV_DECODE_PERF_EN
        if (!r) begin
            m_icnt = 32'd0;
            m_scnt = 32'd0;
        end else begin
            if (iv && rdy && !fl) m_icnt = m_icnt + 32'd1;
            if (iv && !rdy && !fl) m_scnt = m_scnt + 32'd1;
        end
`endif
        @(posedge clk);
        #1;
        m = nx;
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        if (m.valid || !r) begin
            chk("ex_opcode", 32'(ex_opcode), 32'(m.opcode));
            chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
            chk("ex_funct7", 32'(ex_funct7), 32'(m.f7));
            chk("ex_operand_a", ex_operand_a, m.a);
            chk("ex_operand_b", ex_operand_b, m.b);
            chk("ex_store_data", ex_store_data, m.sd);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rd", 32'(ex_rd), 32'(m.rd));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
            chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
            chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
            chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
        end
`ifdef RV_DECODE_PERF_EN
        chk("instr_cnt", instr_cnt, m_icnt);
        chk("stall_cnt", stall_cnt, m_scnt);
`endif
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [13];
        ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13,
                7'h00, 7'h7F, 7'h0B, 7'h2B};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 12)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       ins[31:25] = 7'h00;
            1:       ins[31:25] = 7'h20;
            default: ins[31:25] = ins[31:25];
        endcase
        return ins;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        m     = '0;
`ifdef RV_DECODE_PERF_EN
        m_icnt = 32'd0;
        m_scnt = 32'd0;
        snap   = 32'd0;
`endif
        rst_n = 1'b0; if_valid = 1'b1; if_instr = 32'hFFF0_0093; if_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; flush = 1'b0; ex_ready = 1'b1;

        // Reset held two cycles with fetch valid: everything stays zero
        apply(1'b0, 1'b1, 32'hFFF0_0093, 32'h100, 32'h55, 32'h66, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 32'hFFF0_0093, 32'h100, 32'h55, 32'h66, 1'b0, 1'b1);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);

        // ADDI x1,x0,-1
        apply(1'b1, 1'b1, 32'hFFF0_0093, 32'h100, 32'h55, 32'h66, 1'b0, 1'b1);
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_opcode", 32'(ex_opcode), 32'h13);
        chk("addi_funct7", 32'(ex_funct7), 32'd0);
        chk("addi_opb", ex_operand_b, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(ex_rd), 32'd1);
        chk("addi_rw", 32'(ex_reg_write), 32'd1);

        // SUB x3,x1,x2
        apply(1'b1, 1'b1, 32'h4020_81B3, 32'h104, 32'd10, 32'd3, 1'b0, 1'b1);
        chk("sub_funct7", 32'(ex_funct7), 32'h20);
        chk("sub_opa", ex_operand_a, 32'd10);
        chk("sub_opb", ex_operand_b, 32'd3);
        chk("sub_rd", 32'(ex_rd), 32'd3);

        // LW x5 then ADD x6,x5,x5: one bubble, then the ADD goes in
        apply(1'b1, 1'b1, 32'h0000_A283, 32'h108, 32'h200, 32'h0, 1'b0, 1'b1);
        chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
        apply(1'b1, 1'b1, 32'h0052_8333, 32'h10C, 32'd7, 32'd7, 1'b0, 1'b1);
        chk("lu_if_ready", 32'(obs_rdy), 32'd0);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        apply(1'b1, 1'b1, 32'h0052_8333, 32'h10C, 32'd7, 32'd7, 1'b0, 1'b1);
        chk("lu_accept", 32'(obs_rdy), 32'd1);
        chk("lu_add_rd", 32'(ex_rd), 32'd6);

        // Back-pressure for three cycles
`ifdef RV_DECODE_PERF_EN
        snap = m_scnt;
`endif
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 32'h0010_0093, 32'h110, 32'd1, 32'd2, 1'b0, 1'b0);
            chk("bp_if_ready", 32'(obs_rdy), 32'd0);
            chk("bp_hold_rd", 32'(ex_rd), 32'd6);
        end
`ifdef RV_DECODE_PERF_EN
        chk("bp_stall_delta", stall_cnt, snap + 32'd3);
`endif
        apply(1'b1, 1'b1, 32'h0010_0093, 32'h110, 32'd1, 32'd2, 1'b0, 1'b1);
        chk("bp_release_rd", 32'(ex_rd), 32'd1);

        // Flush with a valid ID/EX and a valid fetch
`ifdef RV_DECODE_PERF_EN
        snap = m_icnt;
`endif
        apply(1'b1, 1'b1, 32'h0020_0113, 32'h114, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("flush_if_ready", 32'(obs_rdy), 32'd1);
        chk("flush_kill", 32'(ex_valid), 32'd0);
`ifdef RV_DECODE_PERF_EN
        chk("flush_icnt", instr_cnt, snap);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), rand_instr(),
                  $urandom, $urandom, $urandom, ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
